// File: rtl/dsp_c_arb_pkg.sv
// Shared types and constants for the DSP C-port arbiter.
// Build option: DSP_C_ARB_PERF_EN adds per-requester perf counters.
package dsp_c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    CLEAR = 2'd2
  } arb_state_e;

  localparam int DW_DEF = 48;
  localparam int PERF_W = 16;

endpackage

// File: rtl/dsp_c_rr_pick.sv
// Round-robin first-set finder: lowest set bit of mask_i
// at or after ptr_i, wrapping past N-1 back to 0.
module dsp_c_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int            j;
  logic [IW-1:0] js;

  // Scan downward so the candidate closest to ptr_i wins last.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    js    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      js = IW'(j);
      if (mask_i[js]) begin
        idx_o = js;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dsp_c_port_arbiter.sv
// Round-robin arbiter sharing one DSP C operand port, with clear
// pulses and a requester tag aligned to the C register output.
// Build option: DSP_C_ARB_PERF_EN adds perf counters and ports.
module dsp_c_port_arbiter
  import dsp_c_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = DW_DEF,
  parameter int CREG      = 1,
  parameter int MAX_BURST = 8
) (
  input  logic                     CLK_creg,
  input  logic                     RSTC,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_lock,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     dsp_en,
  input  logic                     clr_req,
  output logic                     clr_done,
  output logic [DW-1:0]            c_out,
  output logic                     cec_out,
  output logic                     dsp_rst_out,
  output logic                     tag_valid,
  output logic [$clog2(NREQ)-1:0]  tag_id
`ifdef DSP_C_ARB_PERF_EN
  ,
  input  logic [$clog2(NREQ)-1:0]  perf_sel,
  output logic [PERF_W-1:0]        perf_beats,
  output logic [PERF_W-1:0]        perf_wait
`endif
);

  localparam int IW = $clog2(NREQ);

  arb_state_e    state_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] grant_q;
  logic [IW-1:0] rr_nxt;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic [7:0]    beat_cnt_q;
  logic [7:0]    beat_cnt_d;
  logic          clr_pend_q;
  logic          clr_prev_q;
  logic          clr_rise;
  logic          clr_cyc;
  logic [DW-1:0] c_hold_q;
  logic [DW-1:0] data_arr [NREQ];
  logic          busy;
  logic          acc;
  logic          last_beat;
  logic          drop;
  logic          rel;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DW +: DW];
  end

  dsp_c_rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .mask_i (req_valid),
    .ptr_i  (rr_ptr_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign busy       = (state_q == BUSY);
  assign clr_cyc    = (state_q == CLEAR);
  assign acc        = busy & req_valid[grant_q] & dsp_en;
  assign beat_cnt_d = beat_cnt_q + 8'd1;
  assign last_beat  = acc & (~req_lock[grant_q] |
                      (beat_cnt_d == 8'(MAX_BURST)));
  assign drop       = busy & ~req_valid[grant_q] & dsp_en;
  assign rel        = last_beat | drop;
  assign rr_nxt     = (grant_q == IW'(NREQ - 1)) ? '0
                    : grant_q + 1'b1;
  assign clr_rise   = clr_req & ~clr_prev_q;

  assign cec_out     = acc;
  assign dsp_rst_out = clr_cyc;
  assign clr_done    = clr_cyc;
  assign c_out       = acc ? data_arr[grant_q] : c_hold_q;

  // Only the granted requester may see ready, and only when enabled.
  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_q] = dsp_en;
  end

  // Arbitration FSM; a clear raised mid-burst waits for burst end.
  always_ff @(posedge CLK_creg or negedge RSTC) begin
    if (!RSTC) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      clr_pend_q <= 1'b0;
      clr_prev_q <= 1'b0;
      c_hold_q   <= '0;
    end else begin
      clr_prev_q <= clr_req;
      if (clr_rise) clr_pend_q <= 1'b1;
      if (acc) c_hold_q <= data_arr[grant_q];
      unique case (state_q)
        IDLE: begin
          if (clr_rise || clr_pend_q) begin
            state_q <= CLEAR;
          end else if (pick_any) begin
            grant_q    <= pick_idx;
            beat_cnt_q <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (acc) beat_cnt_q <= beat_cnt_d;
          if (rel) begin
            rr_ptr_q <= rr_nxt;
            state_q  <= IDLE;
          end
        end
        CLEAR: begin
          clr_pend_q <= clr_rise;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  if (CREG != 0) begin : g_tag_reg
    logic          tv_q;
    logic [IW-1:0] tid_q;

    // Delay the tag one cycle to line up with the C register output.
    always_ff @(posedge CLK_creg or negedge RSTC) begin
      if (!RSTC) begin
        tv_q  <= 1'b0;
        tid_q <= '0;
      end else begin
        tv_q  <= acc & ~clr_cyc;
        tid_q <= grant_q;
      end
    end

    assign tag_valid = tv_q;
    assign tag_id    = tid_q;
  end else begin : g_tag_comb
    assign tag_valid = acc;
    assign tag_id    = grant_q;
  end

`ifdef DSP_C_ARB_PERF_EN
  logic [PERF_W-1:0] beats_q [NREQ];
  logic [PERF_W-1:0] wait_q  [NREQ];

  // Saturating per-requester beat and wait counters.
  always_ff @(posedge CLK_creg or negedge RSTC) begin
    if (!RSTC) begin
      for (int i = 0; i < NREQ; i++) begin
        beats_q[i] <= '0;
        wait_q[i]  <= '0;
      end
    end else if (clr_cyc) begin
      for (int i = 0; i < NREQ; i++) begin
        beats_q[i] <= '0;
        wait_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc && grant_q == IW'(i) && beats_q[i] != '1)
          beats_q[i] <= beats_q[i] + 1'b1;
        if (req_valid[i] && !(busy && grant_q == IW'(i)) &&
            wait_q[i] != '1)
          wait_q[i] <= wait_q[i] + 1'b1;
      end
    end
  end

  // Registered readout of the selected requester.
  always_ff @(posedge CLK_creg or negedge RSTC) begin
    if (!RSTC) begin
      perf_beats <= '0;
      perf_wait  <= '0;
    end else begin
      perf_beats <= beats_q[perf_sel];
      perf_wait  <= wait_q[perf_sel];
    end
  end
`endif

endmodule
